// File: rtl/spi_flash_rd_arb.sv
// spi_flash_rd_arb: round-robin arbiter issuing one SPI-flash READ (0x03) per grant.
// SPI mode 0; reply bytes are packed little-endian into the 32-bit response word.
module spi_flash_rd_arb #(
  parameter int NUM_REQ = 2,
  parameter int CLK_DIV = 2,
  parameter int CS_IDLE = 4
) (
  input  logic                    sys_clk_i,
  input  logic                    sys_rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ*24-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0]      req_cs_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  output logic [31:0]             rsp_data_o,
  output logic                    busy_o,
  output logic                    spi_clk_o,
  output logic [1:0]              spi_cs_n_o,
  output logic                    spi_mosi_o,
  input  logic                    spi_miso_i
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(CLK_DIV + CS_IDLE + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;
  state_t state, state_d;
  logic [IW-1:0] rr, g, gsel;
  logic found, cs_sel, phase, tick, last;
  logic [63:0] sr;
  logic [31:0] rx;
  logic [CW-1:0] cnt;
  logic [5:0] bit_cnt;
  always_comb begin
    found = 1'b0;
    g = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (!found && req_valid_i[(int'(rr) + i) % NUM_REQ]) begin
        found = 1'b1;
        g = IW'((int'(rr) + i) % NUM_REQ);
      end
  end
  assign tick = cnt == CW'(CLK_DIV - 1);
  assign last = state == SHIFT && tick && phase && &bit_cnt;
  assign req_ready_o = (state == IDLE && found && !sys_rst_i) ? NUM_REQ'(1) << g : '0;
  assign rsp_valid_o = state == DONE ? NUM_REQ'(1) << gsel : '0;
  assign busy_o = state != IDLE || |req_ready_o;
  assign spi_clk_o = state == SHIFT && phase;
  assign spi_cs_n_o = state == SHIFT ? ~(2'b01 << cs_sel) : 2'b11;
  assign spi_mosi_o = state == SHIFT && sr[63];
  always_comb begin
    state_d = state;
    state_d = (state == IDLE && found) ? SHIFT :
              last ? DONE :
              state == DONE ? GAP :
              (state == GAP && cnt == CW'(CS_IDLE - 1)) ? IDLE : state;
  end
  always_ff @(posedge sys_clk_i)
    if (sys_rst_i) state <= IDLE;
    else state <= state_d;
  // cnt times SCK half-periods in SHIFT and the cs_n-high gap in GAP
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rr <= '0;
      gsel <= '0;
      cs_sel <= 1'b0;
      sr <= '0;
      rx <= '0;
      cnt <= '0;
      phase <= 1'b0;
      bit_cnt <= '0;
      rsp_data_o <= '0;
    end else begin
      cnt <= ((state == SHIFT && !tick) || state == GAP) ? cnt + 1'b1 : '0;
      if (state == IDLE && found) begin
        rr <= g == IW'(NUM_REQ - 1) ? '0 : g + 1'b1;
        gsel <= g;
        cs_sel <= req_cs_i[g];
        sr <= {8'h03, req_addr_i[24*g +: 24], 32'h0};
      end
      if (state == SHIFT && tick) phase <= ~phase;
      if (state == SHIFT && tick && !phase && bit_cnt[5]) rx <= {rx[30:0], spi_miso_i};
      if (state == SHIFT && tick && phase) begin
        sr <= sr << 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (last) rsp_data_o <= {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
    end
  end
endmodule
